// File: rtl/sseg_scan_driver_if.sv
// Display driver bus: shadow-load inputs from the datapath side and
// multiplexed segment/digit-enable outputs toward the board pins.
interface sseg_scan_driver_if #(
    parameter int DIGITS = 4
) ();
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   dp_mask;
    logic [DIGITS-1:0]   blink_mask;
    logic                lz_blank;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    modport master (
        output value, load, dp_mask, blink_mask, lz_blank,
        input  seg, dp, an
    );

    modport slave (
        input  value, load, dp_mask, blink_mask, lz_blank,
        output seg, dp, an
    );
endinterface

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with a shadowed value,
// anti-ghosting guard, leading-zero blanking, decimal points and per-digit blink.
module sseg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 50000,
    parameter int GUARD          = 16,
    parameter int BLINK_SCANS    = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    sseg_scan_driver_if.slave  bus
);
    localparam int PW = (PRESCALE > 1)    ? $clog2(PRESCALE)    : 1;
    localparam int IW = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
    localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]       prescaler_q, prescaler_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [4*DIGITS-1:0] shadow_value_q, shadow_value_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]   shadow_blink_q, shadow_blink_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                slot_wrap;
    logic                scan_wrap;
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic                cur_blink;
    logic                higher_nonzero;
    logic                lz_hit;
    logic                dark;
    logic                in_guard;
    logic [6:0]          seg_lit;
    logic [DIGITS-1:0]   an_lit;

    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_wrap = (prescaler_q == PW'(PRESCALE - 1));
        scan_wrap = slot_wrap && (idx_q == IW'(DIGITS - 1));

        prescaler_d   = slot_wrap ? '0 : prescaler_q + 1'b1;
        idx_d         = idx_q;
        scan_cnt_d    = scan_cnt_q;
        blink_phase_d = blink_phase_q;
        if (slot_wrap) begin
            idx_d = scan_wrap ? '0 : idx_q + 1'b1;
        end
        if (scan_wrap) begin
            if (scan_cnt_q == SW'(BLINK_SCANS - 1)) begin
                scan_cnt_d    = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end

        shadow_value_d = bus.load ? bus.value      : shadow_value_q;
        shadow_dp_d    = bus.load ? bus.dp_mask    : shadow_dp_q;
        shadow_blink_d = bus.load ? bus.blink_mask : shadow_blink_q;
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        cur_nibble     = 4'h0;
        cur_dp         = 1'b0;
        cur_blink      = 1'b0;
        higher_nonzero = 1'b0;
        in_guard       = (prescaler_q < PW'(GUARD));
        an_lit         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nibble = shadow_value_q[4*i +: 4];
                cur_dp     = shadow_dp_q[i];
                cur_blink  = shadow_blink_q[i];
                an_lit[i]  = !in_guard;
            end
            if ((IW'(i) >= idx_q) && (shadow_value_q[4*i +: 4] != 4'h0)) begin
                higher_nonzero = 1'b1;
            end
        end

        lz_hit  = bus.lz_blank && (idx_q != '0) && !higher_nonzero;
        dark    = blink_phase_q && cur_blink;
        seg_lit = (lz_hit || dark) ? 7'h00 : decode_hex(cur_nibble);

        seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        dp_d  = SEG_ACTIVE_LOW ? ~(cur_dp && !dark) : (cur_dp && !dark);
        an_d  = AN_ACTIVE_LOW ? ~an_lit : an_lit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q    <= '0;
            idx_q          <= '0;
            scan_cnt_q     <= '0;
            blink_phase_q  <= 1'b0;
            shadow_value_q <= '0;
            shadow_dp_q    <= '0;
            shadow_blink_q <= '0;
            seg_q          <= SEG_OFF;
            dp_q           <= DP_OFF;
            an_q           <= AN_OFF;
        end else begin
            prescaler_q    <= prescaler_d;
            idx_q          <= idx_d;
            scan_cnt_q     <= scan_cnt_d;
            blink_phase_q  <= blink_phase_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blink_q <= shadow_blink_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
    assign bus.an  = an_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver: stimulus pushes model predictions,
// an independent monitor pops and compares them against the pins.
module tb_sseg_scan_driver;
    localparam int DIGITS      = 4;
    localparam int PRESCALE    = 4;
    localparam int GUARD       = 1;
    localparam int BLINK_SCANS = 2;

    typedef struct packed {
        logic [6:0]        seg;
        logic              dp;
        logic [DIGITS-1:0] an;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int unsigned       model_t = 0;
    logic [15:0]       model_value = '0;
    logic [DIGITS-1:0] model_dp = '0;
    logic [DIGITS-1:0] model_blink = '0;

    logic [6:0] seg_table [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    always #5 clk = ~clk;

    sseg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    sseg_scan_driver #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .GUARD(GUARD),
        .BLINK_SCANS(BLINK_SCANS), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Drive one clock of inputs and predict the pins after the coming edge
    // from elapsed time since reset (prescaler, digit and blink phase by division).
    task automatic applyStimulus(input logic r, input logic [15:0] v, input logic ld,
                                 input logic [DIGITS-1:0] dpm, input logic [DIGITS-1:0] bm,
                                 input logic lz);
        exp_t        e;
        int          pre, idx, scans, phase;
        logic [3:0]  nib;
        logic        blank, dark;
        @(negedge clk);
        rst            = r;
        bus.value      = v;
        bus.load       = ld;
        bus.dp_mask    = dpm;
        bus.blink_mask = bm;
        bus.lz_blank   = lz;
        if (r) begin
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            e.an  = '1;
        end else begin
            pre   = int'(model_t % PRESCALE);
            idx   = int'((model_t / PRESCALE) % DIGITS);
            scans = int'(model_t / (PRESCALE * DIGITS));
            phase = (scans / BLINK_SCANS) % 2;
            nib   = 4'((model_value >> (4 * idx)) & 16'hF);
            blank = lz && (idx > 0) && ((model_value >> (4 * idx)) == 16'h0);
            dark  = (phase == 1) && model_blink[idx];
            e.seg = (blank || dark) ? 7'h7F : ~seg_table[nib];
            e.dp  = dark ? 1'b1 : ~model_dp[idx];
            e.an  = (pre < GUARD) ? '1 : ~(DIGITS'(1) << idx);
        end
        exp_q.push_back(e);
        if (r) begin
            model_t     = 0;
            model_value = '0;
            model_dp    = '0;
            model_blink = '0;
        end else begin
            model_t++;
            if (ld) begin
                model_value = v;
                model_dp    = dpm;
                model_blink = bm;
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (bus.seg !== e.seg || bus.dp !== e.dp || bus.an !== e.an) begin
            miscompares++;
            $display("[TB] FAIL pins @%0t: got seg=%b dp=%b an=%b, expected seg=%b dp=%b an=%b",
                     $time, bus.seg, bus.dp, bus.an, e.seg, e.dp, e.an);
        end
    endtask

    // Monitor: after every edge, compare the pins against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic idle(input int n, input logic [15:0] v, input logic [3:0] dpm,
                        input logic [3:0] bm, input logic lz);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, v, 1'b0, dpm, bm, lz);
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        logic [15:0] rv;
        logic        rlz;
        bus.value      = '0;
        bus.load       = 1'b0;
        bus.dp_mask    = '0;
        bus.blink_mask = '0;
        bus.lz_blank   = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        idle(20, 16'h0, 4'h0, 4'h0, 1'b0);

        applyStimulus(1'b0, 16'h12AF, 1'b1, 4'h0, 4'h0, 1'b0);
        idle(20, 16'h0, 4'h0, 4'h0, 1'b0);

        applyStimulus(1'b0, 16'h0070, 1'b1, 4'h0, 4'h0, 1'b1);
        idle(20, 16'h0, 4'h0, 4'h0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1);
        idle(20, 16'h0, 4'h0, 4'h0, 1'b1);

        applyStimulus(1'b0, 16'h4321, 1'b1, 4'h0, 4'b0001, 1'b0);
        idle(140, 16'h0, 4'h0, 4'h0, 1'b0);

        idle(6, 16'h0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 16'h89CD, 1'b1, 4'h0, 4'h0, 1'b0);
        idle(9, 16'h0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        idle(10, 16'h0, 4'h0, 4'h0, 1'b0);

        applyStimulus(1'b0, 16'h0003, 1'b1, 4'b0100, 4'h0, 1'b1);
        idle(20, 16'h0, 4'h0, 4'h0, 1'b1);

        rlz = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 4; k++) begin
                rv[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            if ($urandom_range(0, 63) == 0) rlz = ~rlz;
            applyStimulus($urandom_range(0, 299) == 0, rv, $urandom_range(0, 15) == 0,
                          4'($urandom), 4'($urandom), rlz);
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Multiplexed N-digit seven-segment display driver. Holds a shadow copy of a packed hex value and time-multiplexes one digit at a time onto a shared segment bus with a one-hot digit enable. Adds configurable digit count, scan rate, output polarity, ghosting guard, leading-zero blanking, decimal points and per-digit blink. Sits between counter/datapath logic and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
PRESCALE, 50000, clocks per digit slot (>= GUARD+2)
GUARD, 16, clocks at slot start with all digit enables inactive (anti-ghosting)
BLINK_SCANS, 64, full scan cycles per blink half-period (>= 1)
SEG_ACTIVE_LOW, 1, 1: seg/dp driven low when lit
AN_ACTIVE_LOW, 1, 1: an driven low when digit enabled

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
value  in  4*DIGITS  packed hex digits; digit i = value[4i+3:4i], digit 0 rightmost
load  in  1  1: capture value, dp_mask, blink_mask into shadow registers on this edge
dp_mask  in  DIGITS  1: light decimal point of digit i
blink_mask  in  DIGITS  1: digit i blinks
lz_blank  in  1  1: leading-zero blanking enabled (live, not shadowed)
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an  out  DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW

Behaviour:
- Reset: prescaler=0, idx=0, scan_cnt=0, blink_phase=0, shadows=0; seg, dp, an all inactive level (SEG_ACTIVE_LOW=1 -> seg=7'h7F, dp=1; AN_ACTIVE_LOW=1 -> an all 1s). Reset overrides load.
- Shadow: load=1 captures on the edge; the displayed digit changes only from the next registered output update. Mid-slot load is allowed; no slot restart.
- Prescaler counts 0..PRESCALE-1, then wraps to 0; on wrap, idx advances, DIGITS-1 wraps to 0.
- On idx wrap DIGITS-1->0, scan_cnt increments; at BLINK_SCANS-1 it wraps to 0 and blink_phase toggles.
- All outputs registered; one clock latency from prescaler/idx state to pins.
- an: inactive while prescaler < GUARD; otherwise only bit idx active. seg/dp may change during the guard.
- Decode (active-high, gfedcba): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110 E=1111001 F=1110001. Inverted at the pin when SEG_ACTIVE_LOW=1.
- Leading-zero blanking: when lz_blank=1, digit i (i>0) is blanked if its nibble and every higher nibble are 0. Digit 0 is never LZ-blanked. A blanked digit drives seg off, but dp is still driven from dp_mask.
- Blink: when blink_phase=1 and blink_mask[i]=1, seg and dp for digit i are off. an still scans normally.
- DIGITS=1: idx stays 0; an active except during the guard.

Test Plan:
- DIGITS=4, PRESCALE=4, GUARD=1, active-low; reset 3 clks, release -> seg=7'h7F, an=4'hF during reset; after release an sequence per slot: 1111,1110,1110,1110 then 1111,1101,...; period 16 clks.
- load value=16'h12AF, dp_mask=0 -> digit0 seg=~7'b1110001 (0x0E), digit1 ~1110111, digit2 ~1011011, digit3 ~0000110.
- lz_blank=1, value=16'h0070 -> digits 3,2 seg=7'h7F; digit1 shows ~0000111; digit0 shows ~0111111. value=0 -> only digit0 lit, showing "0".
- blink_mask=4'b0001, BLINK_SCANS=2 -> digit0 lit for 2 scans (32 clks), dark for 2 scans, repeating; digits 1-3 are unaffected.
- load asserted mid-slot with new value -> the currently shown digit updates one clk after the load edge; idx/prescaler are not disturbed. Assert rst mid-slot -> next clk outputs are inactive and idx=0.
- dp_mask=4'b0100 with lz_blank blanking digit2 -> digit2 seg off, dp=0 (lit) during its slot.
